// File: rtl/cpu_mem_pkg.sv
// Shared types and limits for the CPU-side memory responder.
// The state encoding is common to the responder and its wait counter.
package cpu_mem_pkg;

   localparam int MEM_ADDR_WIDTH  = 12;
   localparam int MEM_DATA_WIDTH  = 16;
   localparam int MAX_WAIT_STATES = 7;
   localparam int WAIT_CNT_W      = 3;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      CAPTURE,
      RESP
   } mem_state_t;

   // States in which the RAM chip select is held.
   function automatic logic ram_selected(input mem_state_t s);
      return (s == WRITE) || (s == READ) || (s == CAPTURE);
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Read wait-state down-counter: loads WAIT_STATES on READ entry and
// flags done once it reaches zero.
module mem_wait_counter
   import cpu_mem_pkg::*;
#(
   parameter int WAIT_STATES = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic done
);

   localparam logic [WAIT_CNT_W-1:0] LOAD_VAL = WAIT_CNT_W'(WAIT_STATES);

   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/single_port_sync_ram_large.sv
// Single-port synchronous RAM: writes and read sampling on the rising edge,
// registered read data driven onto the shared bus while cs & oe & !we.
module single_port_sync_ram_large #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  cs,
   input  logic                  we,
   input  logic                  oe,
   input  logic [ADDR_WIDTH-1:0] addr,
   inout  wire  [DATA_WIDTH-1:0] data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (cs && we) begin
         mem[addr] <= data;
      end
      if (cs && !we) begin
         rd_q <= mem[addr];
      end
   end

   assign data = (cs && oe && !we) ? rd_q : 'z;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one word request at a time from the sequencer,
// sequences the RAM strobes and bus, and returns a one-cycle response pulse.
module mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  wire  [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe
);

   mem_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  req_we_q, req_we_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  mem_cs_q, mem_cs_d;
   logic                  mem_we_q, mem_we_d;
   logic                  mem_oe_q, mem_oe_d;
   logic                  accept;
   logic                  wait_load;
   logic                  wait_done;

   assign req_ready = ((state_q == IDLE) || (state_q == RESP)) && !rst;
   assign accept    = req_ready && req_valid;

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      wdata_d     = wdata_q;
      req_we_d    = req_we_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               mem_addr_d = req_addr;
               wdata_d    = req_wdata;
               req_we_d   = req_we;
               state_d    = req_we ? WRITE : READ;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE:   state_d = RESP;
         READ:    if (wait_done) state_d = CAPTURE;
         CAPTURE: begin
            rsp_rdata_d = mem_data;
            state_d     = RESP;
         end
         default: state_d = IDLE;
      endcase

      // Reads complete when CAPTURE ends; writes when their RESP cycle ends,
      // so both report two cycles after acceptance.
      rsp_valid_d = (state_q == CAPTURE) || ((state_q == RESP) && req_we_q);
      mem_cs_d    = ram_selected(state_d);
      mem_we_d    = (state_d == WRITE);
      mem_oe_d    = (state_d == READ) || (state_d == CAPTURE);
   end

   assign wait_load = (state_d == READ) && (state_q != READ);

   mem_wait_counter #(
      .WAIT_STATES(WAIT_STATES)
   ) u_wait (
      .clk (clk),
      .rst (rst),
      .load(wait_load),
      .dec (state_q == READ),
      .done(wait_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_addr_q  <= '0;
         req_we_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_oe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         req_we_q    <= req_we_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_oe_q    <= mem_oe_d;
      end
      wdata_q <= wdata_d;
   end

   // The bus is driven only during the WRITE cycle; mem_we is high only there.
   assign mem_data  = mem_we_q ? wdata_q : 'z;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_oe    = mem_oe_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder with the RAM beside it: directed tables streamed
// through the handshake plus hand sequences for reset, hold and wait states.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [11:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        req_ready, rsp_valid, mem_cs, mem_we, mem_oe;
   logic [15:0] rsp_rdata;
   logic [11:0] mem_addr;
   wire  [15:0] mem_data;

   logic        r3_valid = 1'b0;
   logic        r3_we = 1'b0;
   logic [11:0] r3_addr = '0;
   logic [15:0] r3_wdata = '0;
   logic        r3_ready, p3_valid, m3_cs, m3_we, m3_oe;
   logic [15:0] p3_rdata;
   logic [11:0] m3_addr;
   wire  [15:0] m3_data;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .WAIT_STATES(0)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe));

   single_port_sync_ram_large #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) u_ram (
      .clk(clk), .cs(mem_cs), .we(mem_we), .oe(mem_oe), .addr(mem_addr), .data(mem_data));

   mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
      .req_we(r3_we), .req_addr(r3_addr), .req_wdata(r3_wdata),
      .rsp_valid(p3_valid), .rsp_rdata(p3_rdata), .mem_addr(m3_addr),
      .mem_data(m3_data), .mem_cs(m3_cs), .mem_we(m3_we), .mem_oe(m3_oe));

   single_port_sync_ram_large #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) u_ram3 (
      .clk(clk), .cs(m3_cs), .we(m3_we), .oe(m3_oe), .addr(m3_addr), .data(m3_data));

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t        vecs[$];
   int          acc[64];
   int          rsp_cyc[$];
   logic [15:0] rsp_dat[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        prev_rsp = 1'b0;

   logic [15:0] prog [16] = '{16'h110C, 16'h310E, 16'h110D, 16'h410B,
                              16'h310D, 16'h110E, 16'h2109, 16'h310E,
                              16'h6100, 16'h9102, 16'h7000, 16'h0005,
                              16'h0007, 16'h0000, 16'h0000, 16'hFFFF};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Response monitor for the main instance.
   always @(negedge clk) begin
      if (rsp_valid) begin
         chk("rsp_single_pulse", {31'd0, prev_rsp}, 32'd0);
         rsp_cyc.push_back(cyc);
         rsp_dat.push_back(rsp_rdata);
      end
      prev_rsp = rsp_valid;
   end

   task automatic add_vec(input logic we, input logic [11:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = d; v.exp_rdata = exp_rd; v.exp_lat = 2;
      vecs.push_back(v);
   endtask

   // Presents the table as fast as req_ready allows, then scores the responses.
   task automatic run_stream(input string tag);
      int  i = 0;
      int  guard = 0;
      bit  take;
      rsp_cyc.delete();
      rsp_dat.delete();
      while (i < vecs.size() && guard < 2000) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_we    = vecs[i].we;
         req_addr  = vecs[i].addr;
         req_wdata = vecs[i].wdata;
         take = req_ready;
         if (take) acc[i] = cyc + 1;
         @(posedge clk);
         if (take) i++;
         guard++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, "_accepted"}, i, vecs.size());
      guard = 0;
      while (rsp_cyc.size() < vecs.size() && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_rsp_count"}, rsp_cyc.size(), vecs.size());
      for (int k = 0; k < vecs.size() && k < rsp_cyc.size(); k++) begin
         chk($sformatf("%s_lat_%0d", tag, k), rsp_cyc[k] - acc[k], vecs[k].exp_lat);
         if (!vecs[k].we)
            chk($sformatf("%s_rdata_%0d@%0h", tag, k, vecs[k].addr), rsp_dat[k], vecs[k].exp_rdata);
         if (k > 0)
            chk($sformatf("%s_gap_%0d", tag, k), acc[k] - acc[k-1], vecs[k-1].we ? 2 : 3);
      end
   endtask

   // One isolated request on the main instance with per-cycle strobe checks.
   task automatic single(input string tag, input logic we, input logic [11:0] a,
                         input logic [15:0] d, input logic [15:0] exp_rd);
      @(negedge clk);
      chk({tag, "_ready"}, req_ready, 1);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, "_e0_cs"}, mem_cs, 1);
      chk({tag, "_e0_we"}, mem_we, we);
      chk({tag, "_e0_oe"}, mem_oe, !we);
      chk({tag, "_e0_addr"}, mem_addr, a);
      chk({tag, "_e0_rsp"}, rsp_valid, 0);
      if (we) chk({tag, "_e0_bus"}, mem_data, d);
      @(posedge clk); #1;
      chk({tag, "_e1_rsp"}, rsp_valid, 0);
      if (we) begin
         chk({tag, "_e1_cs"}, mem_cs, 0);
      end else begin
         chk({tag, "_e1_oe"}, mem_oe, 1);
         chk({tag, "_e1_bus"}, mem_data, exp_rd);
      end
      @(posedge clk); #1;
      chk({tag, "_e2_rsp"}, rsp_valid, 1);
      chk({tag, "_e2_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_e2_cs"}, mem_cs, 0);
      @(posedge clk); #1;
      chk({tag, "_e3_rsp"}, rsp_valid, 0);
   endtask

   initial begin
      int lat3;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_strobes", {mem_cs, mem_we, mem_oe}, 0);
      rst = 1'b0;
      #1;
      chk("rst_release_ready", req_ready, 1);

      // Write then read 0x100
      single("wr100", 1'b1, 12'h100, 16'h110C, 16'h0000);
      single("rd100", 1'b0, 12'h100, 16'h0000, 16'h110C);
      @(negedge clk);
      chk("idle_addr_hold", mem_addr, 12'h100);

      // Program load with back-to-back writes, then full read-back
      vecs.delete();
      for (int k = 0; k < 16; k++) add_vec(1'b1, 12'h100 + 12'(k), prog[k], 16'h0000);
      for (int k = 0; k < 16; k++) add_vec(1'b0, 12'h100 + 12'(k), 16'h0000, prog[k]);
      run_stream("prog");

      // Three wait states on the second instance
      @(negedge clk);
      r3_valid = 1'b1; r3_we = 1'b1; r3_addr = 12'h10C; r3_wdata = 16'h0007;
      @(posedge clk); #1;
      r3_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      r3_valid = 1'b1; r3_we = 1'b0; r3_addr = 12'h10C;
      @(posedge clk); #1;
      r3_valid = 1'b0;
      lat3 = 0;
      for (int k = 1; k <= 10 && lat3 == 0; k++) begin
         @(posedge clk); #1;
         if (p3_valid) lat3 = k;
         else chk($sformatf("w3_oe_held_%0d", k), m3_oe, 1);
      end
      chk("w3_latency", lat3, 5);
      chk("w3_rdata", p3_rdata, 16'h0007);

      // Request fields change while the responder is busy
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h10B;
      @(posedge clk);
      @(negedge clk);
      req_we = 1'b1; req_addr = 12'h10F; req_wdata = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      chk("hold_addr", mem_addr, 12'h10B);
      chk("hold_no_write", mem_we, 0);
      req_we = 1'b0; req_addr = 12'h100;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("hold_rsp", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, 16'h0005);
      repeat (2) @(posedge clk);

      // Reset during the READ cycle
      @(negedge clk);
      rsp_cyc.delete();
      rsp_dat.delete();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h10F;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rstrd_strobes", {mem_cs, mem_we, mem_oe}, 0);
      chk("rstrd_rdata", rsp_rdata, 0);
      chk("rstrd_rsp", rsp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstrd_ready", req_ready, 1);
      repeat (4) @(negedge clk);
      chk("rstrd_dropped", rsp_cyc.size(), 0);
      single("rd10f", 1'b0, 12'h10F, 16'h0000, 16'hFFFF);

      // Alternating writes and reads with no gaps
      vecs.delete();
      add_vec(1'b1, 12'h10D, 16'hAAAA, 16'h0000);
      add_vec(1'b0, 12'h10D, 16'h0000, 16'hAAAA);
      add_vec(1'b1, 12'h10D, 16'h5555, 16'h0000);
      add_vec(1'b0, 12'h10D, 16'h0000, 16'h5555);
      add_vec(1'b1, 12'h10D, 16'hAAAA, 16'h0000);
      add_vec(1'b0, 12'h10D, 16'h0000, 16'hAAAA);
      run_stream("alt");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
